// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward AXI-Stream packet FIFO that only releases committed frames.
// Define AXIS_PKT_FIFO_DROP_BAD_EN to discard frames whose tlast beat carries tuser=1.
module axis_packet_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  output logic                      s_axis_trdy,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_trdy,
  output logic [ADDR_WIDTH:0]       o_frame_count,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count,
  output logic                      o_overflow,
  output logic                      o_bad_frame
);
`ifdef AXIS_PKT_FIFO_DROP_BAD_EN
  localparam logic DROP_BAD = 1'b1;
`else
  localparam logic DROP_BAD = 1'b0;
`endif
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [DATA_WIDTH:0] r_rd_word;
  logic [ADDR_WIDTH:0] r_wr_ptr, r_wr_commit, r_rd_ptr, w_wr_ptr_nxt, w_wr_commit_nxt;
  logic [ADDR_WIDTH:0] r_frame_count;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic r_trdy, r_rd_valid, r_out_valid, r_out_last, r_ovf, r_bad;
  logic w_acc, w_full, w_we, w_commit, w_ovf, w_bad;
  logic w_out_load, w_s1_rdy, w_rd_en, w_pop_last;
  always_comb begin
    w_acc           = s_axis_tvalid & r_trdy;
    w_full          = (r_wr_ptr - r_rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_wr_commit_nxt = r_wr_commit;
    w_we            = 1'b0;
    w_commit        = 1'b0;
    w_ovf           = 1'b0;
    w_bad           = 1'b0;
    if (w_acc) begin
      if (r_state == DROP) begin
        w_ovf       = s_axis_tlast;
        w_state_nxt = s_axis_tlast ? IDLE : DROP;
      end else if (w_full) begin
        // rewind so the partial frame's space is reclaimed
        w_wr_ptr_nxt = r_wr_commit;
        w_ovf        = s_axis_tlast;
        w_state_nxt  = s_axis_tlast ? IDLE : DROP;
      end else if (DROP_BAD & s_axis_tlast & s_axis_tuser) begin
        w_wr_ptr_nxt = r_wr_commit;
        w_bad        = 1'b1;
        w_state_nxt  = IDLE;
      end else begin
        w_we            = 1'b1;
        w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
        w_commit        = s_axis_tlast;
        w_wr_commit_nxt = s_axis_tlast ? r_wr_ptr + 1'b1 : r_wr_commit;
        w_state_nxt     = s_axis_tlast ? IDLE : WRITE;
      end
    end
  end
  // two-stage prefetch: RAM read register, then output register
  assign w_out_load = ~r_out_valid | m_axis_trdy;
  assign w_s1_rdy   = ~r_rd_valid | w_out_load;
  assign w_rd_en    = w_s1_rdy & (r_rd_ptr != r_wr_commit);
  assign w_pop_last = r_out_valid & m_axis_trdy & r_out_last;
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (w_rd_en) r_rd_word <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_trdy        <= 1'b0;
      r_wr_ptr      <= '0;
      r_wr_commit   <= '0;
      r_rd_ptr      <= '0;
      r_rd_valid    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_ovf         <= 1'b0;
      r_bad         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_trdy      <= 1'b1;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_s1_rdy) r_rd_valid <= w_rd_en;
      if (w_out_load) r_out_valid <= r_rd_valid;
      if (w_out_load && r_rd_valid) {r_out_last, r_out_data} <= r_rd_word;
      if (w_commit != w_pop_last) r_frame_count <= w_commit ? r_frame_count + 1'b1 : r_frame_count - 1'b1;
      if ((w_ovf || w_bad) && r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      r_ovf <= w_ovf;
      r_bad <= w_bad;
    end
  end
  assign s_axis_trdy   = r_trdy;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign o_frame_count = r_frame_count;
  assign o_drop_count  = r_drop_count;
  assign o_overflow    = r_ovf;
  assign o_bad_frame   = r_bad;
endmodule

// File: doc/axis_packet_fifo.md
# axis_packet_fifo

Single-clock, parametrised store-and-forward AXI-Stream packet FIFO for the Ethernet datapath. It buffers whole frames and releases a frame downstream only after its last beat has been written. It discards frames that overflow the buffer and, when configured, frames flagged bad by `tuser`. It sits between the MAC rx stream and the UDP/IP parsing logic, or ahead of the tx MAC, wherever a frame must never be presented partially.

## Interface
- `DATA_WIDTH`, default 8: `tdata` width in bits. The RAM word is `DATA_WIDTH+1` bits (data plus `tlast`).
- `ADDR_WIDTH`, default 12: buffer depth is `DEPTH = 2**ADDR_WIDTH` beats.
- `DROP_CNT_WIDTH`, default 16: width of the saturating drop counter.
- `i_clk`, in, 1: the only clock. All logic is on its rising edge.
- `i_reset_n`, in, 1: reset, synchronous and active-low.
- `s_axis_tdata`, in, `DATA_WIDTH`: input beat.
- `s_axis_tvalid`, in, 1: input beat valid.
- `s_axis_tlast`, in, 1: last beat of the frame.
- `s_axis_tuser`, in, 1: frame error flag; sampled only on the `tlast` beat.
- `s_axis_trdy`, out, 1: input ready.
- `m_axis_tdata`, out, `DATA_WIDTH`: output beat.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tlast`, out, 1: last beat of the output frame.
- `m_axis_trdy`, in, 1: downstream ready.
- `o_frame_count`, out, `ADDR_WIDTH+1`: complete frames stored and not yet fully read out.
- `o_drop_count`, out, `DROP_CNT_WIDTH`: total frames dropped; saturates at all-ones.
- `o_overflow`, out, 1: one-cycle pulse when a frame is dropped for lack of space.
- `o_bad_frame`, out, 1: one-cycle pulse when a frame is dropped for `tuser`.

## Operation
- Pointers are `ADDR_WIDTH+1` bits and wrap naturally; the MSB distinguishes full from empty.
- Pointer roles:
  - `wr_ptr`: speculative write pointer.
  - `wr_commit`: end of the last committed frame.
  - `rd_ptr`: read pointer.
- Full condition: `wr_ptr - rd_ptr == DEPTH`.
- `s_axis_trdy` is 1 whenever out of reset. The block never back-pressures; excess data is dropped instead of stalled.
- Write state machine:
  - `IDLE`: accepted beat → write RAM, `wr_ptr+1`. `tlast` commits immediately (stays `IDLE`); otherwise go to `WRITE`.
  - `WRITE`: accepted beat written while not full. On `tlast`: commit (`wr_commit <= wr_ptr+1`), go to `IDLE`.
  - Beat accepted while full, in `IDLE` or `WRITE`: not written; `wr_ptr <= wr_commit`; go to `DROP`. If that beat is also `tlast`, this is the end of the frame: pulse `o_overflow`, count the drop, go to `IDLE`.
  - `DROP`: beats consumed and discarded. On `tlast`: pulse `o_overflow`, increment `o_drop_count`, go to `IDLE`.
  - Bad frame (macro enabled): `tlast` with `tuser=1` in `IDLE` or `WRITE` → `wr_ptr <= wr_commit`, no commit, pulse `o_bad_frame`, increment `o_drop_count`.
- A frame longer than `DEPTH` is always dropped.
- Read side is a prefetch pipeline: a synchronous RAM read stage followed by an output register.
  - Reads are issued only while `rd_ptr != wr_commit`, so uncommitted data is never read.
  - Sustains 1 beat per cycle while `m_axis_trdy=1`.
  - The output register holds its value while `m_axis_tvalid & !m_axis_trdy`.
- `o_frame_count` increments on commit and decrements on an output handshake with `m_axis_tlast=1`. If both happen in the same cycle it is unchanged.
- Simultaneous commit and full read-out of the last stored frame: `rd_ptr`/`wr_commit` comparisons use the updated values, with no lost or duplicated beat.
- Reset mid-frame:
  - All pointers, counters and state are cleared and the partial frame is lost.
  - Beats arriving after reset release are treated as the start of a new frame.
- Reset values of outputs:
  - `s_axis_trdy=0`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`.
  - `o_frame_count=0`, `o_drop_count=0`, `o_overflow=0`, `o_bad_frame=0`.

## Timing
- Edge T accepts a good `tlast` beat → commit at edge T. The first beat of that frame is RAM-read at edge T+1 and registered at edge T+2, so `m_axis_tvalid=1` after edge T+2 when the FIFO was previously empty.
- `o_frame_count` updates at the edge of the commit or read-out event.
- `o_overflow` and `o_bad_frame` are high for exactly the cycle after the `tlast` edge. `o_drop_count` updates at the same edge.
- After `i_reset_n` rises, `s_axis_trdy=1` from the next edge.

## Configuration
- Macro: `AXIS_PKT_FIFO_DROP_BAD_EN`.
- Defined: frames ending with `tuser=1` are discarded as described above.
- Undefined: `s_axis_tuser` is ignored, every frame that fits is committed, and `o_bad_frame` is tied to 0. Overflow dropping is unaffected.

## Test plan
All scenarios use `DATA_WIDTH=8`, `ADDR_WIDTH=4` (DEPTH 16).
- Single frame 0x01..0x05 with `m_axis_trdy=1` → `tvalid` rises 2 cycles after `tlast`; output 0x01..0x05 with `tlast` on 0x05; `o_frame_count` goes 0→1→0.
- Three back-to-back 4-beat frames with `m_axis_trdy=0`, then held at 1 → `o_frame_count=3`; 12 beats out in order with no bubbles.
- 20-beat frame into an empty FIFO → `o_overflow` pulses once; `o_drop_count=1`; nothing output; a following 3-beat frame is delivered intact.
- Macro enabled, 6-beat frame with `tuser=1` on `tlast` → `o_bad_frame` pulse, `o_drop_count=1`, no output. Macro disabled, same stimulus → frame delivered, no pulse.
- Write 10-beat frame, read it, then write 10 more → pointers wrap past 16; data is correct.
- Assert reset after beat 3 of an 8-beat frame → all outputs at reset values; the next 2-beat frame is delivered alone.
